reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 27 ++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file bus: write-back port, two combinational read ports,
// a registered debug read port and the committed-write counter.
interface reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_cnt;

  modport master (
    output wb_en, wb_addr, wb_data, ra_addr, rb_addr, dbg_addr,
    input  ra_data, rb_data, dbg_data, wr_cnt
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, ra_addr, rb_addr, dbg_addr,
    output ra_data, rb_data, dbg_data, wr_cnt
  );
endinterface

// File: rtl/reg_file.sv
// Twelve-entry register file (R0-R7, T, SP, IH, RA).
// Two combinational read ports with write-back bypass, a registered debug
// port and a wrapping count of committed writes.
// Addresses 12 and above are unimplemented and read as zero.
// 4'hF is used as the write-back NOP target.
module reg_file #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] SP_RESET = 16'hBF10
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int unsigned       NUM_REGS   = 12;
  localparam int unsigned       SP_IDX     = 9;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [15:0]       wr_cnt_q;
  logic [DATA_W-1:0] dbg_q;
  logic              wr_commit;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic [DATA_W-1:0] dbg_next;

  // Array lookup; unimplemented addresses fall through to zero.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) v = regs[i];
    end
    return v;
  endfunction

  // A write commits only outside reset and to an implemented address.
  always_comb begin
    wr_commit = rst && bus.wb_en && (bus.wb_addr < NUM_REGS_A);
  end

  // Read ports and the debug next-value all see the in-flight write.
  // For the debug port, this yields the post-write contents.
  always_comb begin
    ra_val   = rd(bus.ra_addr);
    rb_val   = rd(bus.rb_addr);
    dbg_next = rd(bus.dbg_addr);
    if (wr_commit && (bus.wb_addr == bus.ra_addr))  ra_val   = bus.wb_data;
    if (wr_commit && (bus.wb_addr == bus.rb_addr))  rb_val   = bus.wb_data;
    if (wr_commit && (bus.wb_addr == bus.dbg_addr)) dbg_next = bus.wb_data;
  end

  // Register array, write counter and debug register.
  // Reset takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      wr_cnt_q <= '0;
      dbg_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && (bus.wb_addr == ADDR_W'(i))) regs[i] <= bus.wb_data;
      end
      if (wr_commit) wr_cnt_q <= wr_cnt_q + 16'd1;
      dbg_q <= dbg_next;
    end
  end

  assign bus.ra_data  = ra_val;
  assign bus.rb_data  = rb_val;
  assign bus.dbg_data = dbg_q;
  assign bus.wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// A behavioural register-file model is checked against the DUT every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_reg_file;

  localparam logic [15:0] SP_RST = 16'hBF10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  reg_file_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  reg_file #(.DATA_W(16), .ADDR_W(4), .SP_RESET(SP_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the architectural register contents and the counters.
  logic [15:0] m_regs [12];
  logic [15:0] m_cnt;
  logic [15:0] m_dbg;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a < 4'd12) return m_regs[int'(a)];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_port(input logic [3:0] a);
    if (rst && bus.wb_en && bus.wb_addr < 4'd12 && bus.wb_addr == a) return bus.wb_data;
    return m_read(a);
  endfunction

  // Model update on each rising edge, from the inputs present before the edge.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 12; i++) m_regs[i] = 16'h0000;
      m_regs[9] = SP_RST;
      m_cnt = 16'h0000;
      m_dbg = 16'h0000;
    end else begin
      if (bus.wb_en && bus.wb_addr < 4'd12) begin
        m_regs[int'(bus.wb_addr)] = bus.wb_data;
        m_cnt = m_cnt + 16'd1;
      end
      m_dbg = m_read(bus.dbg_addr);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ra",  bus.ra_data,  m_port(bus.ra_addr));
      check("model_rb",  bus.rb_data,  m_port(bus.rb_addr));
      check("model_dbg", bus.dbg_data, m_dbg);
      check("model_cnt", bus.wr_cnt,   m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [3:0] a, input logic [15:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst     = 1'b0;
    set_wr(1'b0, 4'h0, 16'h0000);
    bus.ra_addr  = 4'h0;
    bus.rb_addr  = 4'h0;
    bus.dbg_addr = 4'h0;

    // Two reset cycles, then read every implemented address.
    tick();
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      bus.ra_addr = 4'(i);
      #1;
      check("rst_read", bus.ra_data, (i == 9) ? 16'hBF10 : 16'h0000);
    end
    check("rst_cnt", bus.wr_cnt, 16'h0000);
    check("rst_dbg", bus.dbg_data, 16'h0000);
    rst = 1'b1;
    tick();

    // Same-cycle bypass on R3, then the stored value.
    set_wr(1'b1, 4'd3, 16'h1234);
    bus.ra_addr = 4'd3;
    #1;
    check("byp_r3_pre", bus.ra_data, 16'h1234);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    #1;
    check("byp_r3_post", bus.ra_data, 16'h1234);
    check("cnt_after_r3", bus.wr_cnt, 16'h0001);

    // Write to the NOP target leaves everything untouched.
    set_wr(1'b1, 4'hF, 16'hDEAD);
    bus.ra_addr = 4'hF;
    bus.rb_addr = 4'd3;
    #1;
    check("nop_read15", bus.ra_data, 16'h0000);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    #1;
    check("nop_cnt", bus.wr_cnt, 16'h0001);
    check("nop_r3", bus.rb_data, 16'h1234);
    check("nop_read15_post", bus.ra_data, 16'h0000);

    // Both ports bypass the same address at once.
    set_wr(1'b1, 4'd5, 16'h7777);
    bus.ra_addr = 4'd5;
    bus.rb_addr = 4'd5;
    #1;
    check("byp_both_a", bus.ra_data, 16'h7777);
    check("byp_both_b", bus.rb_data, 16'h7777);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);

    // Debug port: same-edge write visible, and held on the following edge.
    bus.dbg_addr = 4'd8;
    set_wr(1'b1, 4'd8, 16'h5A5A);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    check("dbg_same_edge", bus.dbg_data, 16'h5A5A);
    tick();
    check("dbg_next_edge", bus.dbg_data, 16'h5A5A);
    bus.dbg_addr = 4'd13;
    tick();
    check("dbg_unimpl", bus.dbg_data, 16'h0000);
    check("cnt_before_rst", bus.wr_cnt, 16'h0003);

    // A write during reset is lost, not counted and not bypassed.
    rst = 1'b0;
    set_wr(1'b1, 4'd10, 16'h00AA);
    bus.ra_addr = 4'd10;
    #1;
    check("rstwr_ra_pre", bus.ra_data, 16'h0000);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    #1;
    check("rstwr_ih", bus.ra_data, 16'h0000);
    check("rstwr_cnt", bus.wr_cnt, 16'h0000);
    bus.rb_addr = 4'd3;
    #1;
    check("rst_clears_r3", bus.rb_data, 16'h0000);

    // First edge out of reset commits immediately.
    rst = 1'b1;
    set_wr(1'b1, 4'd11, 16'hCAFE);
    bus.ra_addr = 4'd11;
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    check("resume_ra", bus.ra_data, 16'hCAFE);
    check("resume_cnt", bus.wr_cnt, 16'h0001);

    // Counter wrap: bring to 16'hFFFF, then one more write.
    for (int i = 1; i < 65535; i++) begin
      set_wr(1'b1, 4'(i % 12), 16'(i));
      tick();
    end
    set_wr(1'b0, 4'd0, 16'h0000);
    #1;
    check("cnt_ffff", bus.wr_cnt, 16'hFFFF);
    set_wr(1'b1, 4'd2, 16'hBEEF);
    tick();
    set_wr(1'b0, 4'd0, 16'h0000);
    check("cnt_wrap", bus.wr_cnt, 16'h0000);
    bus.ra_addr = 4'd2;
    #1;
    check("wrap_r2", bus.ra_data, 16'hBEEF);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
